load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 64, the maximum number of bus wait cycles before the access is aborted.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 MemRead  input  1  load request from the control unit.
REQ-006 MemWrite  input  1  store request from the control unit.
REQ-007 Funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
REQ-008 ALUResult  input  32  byte address from the datapath.
REQ-009 WriteData  input  32  store data from the datapath, right-aligned.
REQ-010 ReadData  output  32  formatted load result to the datapath result mux.
REQ-011 Stall  output  1  combinational; when high, the PC and register-file write are held.
REQ-012 AccessErr  output  1  one-cycle pulse flagging a misaligned, illegal or timed-out access.
REQ-013 bus_req, bus_we  output  1 each  bus request and write enable.
REQ-014 bus_addr  output  32  word address, with bits [1:0] always 00.
REQ-015 bus_be  output  4  byte enables.
REQ-016 bus_wdata  output  32  lane-replicated store data.
REQ-017 bus_ack  input  1  bus completion.
REQ-018 bus_rdata  input  32  bus read word.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUS and DONE.
REQ-020 IDLE SHALL behave as follows:
- With MemRead|MemWrite high, Stall=1 combinationally in the same cycle.
- Address, size, we and formatted data SHALL be registered on that edge.
- Next state SHALL be BUS for a legal access, or DONE for an illegal one.
REQ-021 BUS SHALL behave as follows:
- bus_req=1 and Stall=1.
- bus_addr, bus_we, bus_be and bus_wdata SHALL be held stable until the bus_ack cycle.
- On bus_ack=1, go to DONE.
REQ-022 DONE SHALL behave as follows:
- Stall=0 and ReadData is valid.
- The datapath advances PC and writes back on this edge.
- Next state SHALL be IDLE unconditionally, so the same instruction is never re-issued.
REQ-023 Latency with bus_ack in the first BUS cycle SHALL be 3 cycles (IDLE, BUS, DONE) with Stall high for 2 cycles; each extra wait cycle SHALL add 1.
REQ-024 bus_ack SHALL be ignored when bus_req=0.
REQ-025 Byte lanes for stores SHALL be:
- SB: be=0001<<addr[1:0], wdata={4{WriteData[7:0]}}.
- SH: be=0011 (addr[1]=0) or 1100 (addr[1]=1), wdata={2{WriteData[15:0]}}.
- SW: be=1111, wdata=WriteData.
REQ-026 Loads SHALL drive the same bus_be as a store of the same size, with bus_we=0.
REQ-027 Load formatting SHALL select the lane from bus_rdata by addr[1:0]:
- B and H are sign-extended to 32 bits.
- BU and HU are zero-extended.
- W is passed through.
- The result SHALL be registered into ReadData on the ack edge.
REQ-028 ReadData SHALL hold its last value outside DONE and SHALL not change on stores.
REQ-029 An access SHALL be illegal, with no bus request issued, if any of the following holds:
- H/HU with addr[0]=1.
- W with addr[1:0]!=00.
- A load with Funct3 in {011,110,111}.
- A store with Funct3[2]=1 or Funct3=011.
- MemRead and MemWrite both high.
REQ-030 For an illegal access: AccessErr=1 for the IDLE->DONE edge's following cycle (the DONE cycle), and ReadData=0 in DONE.
REQ-031 A wait counter SHALL count BUS cycles; when the count reaches TIMEOUT without bus_ack:
- bus_req drops and the FSM goes to DONE.
- AccessErr=1 in DONE and ReadData=0.
REQ-032 bus_ack arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally, with no error.
REQ-033 With no memory request in IDLE: Stall=0, bus_req=0, AccessErr=0.

Reset
REQ-034 While reset=0 at a clock edge, the following SHALL be cleared: state=IDLE, ReadData=0, AccessErr=0, bus_req=0, bus_we=0, bus_be=0000, bus_addr=0, bus_wdata=0, wait counter=0.
REQ-035 Reset asserted during BUS SHALL drop bus_req on the next edge, and SHALL discard any bus_ack in that cycle.
REQ-036 Stall SHALL be 0 while reset=0.

Verification
REQ-037 LW at 0x100, bus_rdata=0xDEADBEEF, ack after 0 waits -> bus_addr=0x100, be=1111, Stall high for 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-038 LB at 0x103 and LBU at 0x103 with rdata=0x80FF_0000 -> ReadData=0xFFFFFF80 and 0x00000080.
REQ-039 SH at 0x102, WriteData=0x1234ABCD -> bus_we=1, be=1100, wdata=0xABCDABCD, ReadData unchanged.
REQ-040 LW at 0x101 -> no bus_req, AccessErr pulse for 1 cycle, ReadData=0, Stall high for exactly 1 cycle.
REQ-041 LW with no ack and TIMEOUT=4 -> bus_req high for 4 cycles, then AccessErr=1 and ReadData=0; a late ack is ignored.
REQ-042 reset=0 asserted in the second BUS cycle -> next cycle state=IDLE, bus_req=0, Stall=0, ReadData=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Bus-side handshake between the load/store unit (master) and the data memory (slave).
// A request is held on the bus until the slave answers with bus_ack.
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core while a single byte/half/word access runs on the bus.
// Illegal or timed-out accesses complete with AccessErr and a zero load result.
module load_store_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AccessErr,
  load_store_unit_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t      state_reg;
  logic [CW-1:0] wait_cnt_reg;
  logic [1:0]  addr_lo_reg;
  logic [2:0]  funct3_reg;
  logic        we_reg;
  logic        bus_req_reg;
  logic [31:0] bus_addr_reg;
  logic [3:0]  bus_be_reg;
  logic [31:0] bus_wdata_reg;
  logic [31:0] read_data_reg;
  logic        access_err_reg;

  logic [31:0] wdata_fmt;
  logic [3:0]  be_fmt;
  logic [7:0]  rd_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_fmt;
  logic        misalign;
  logic        bad_load;
  logic        bad_store;
  logic        illegal;

  // Store data is replicated into every lane that could be enabled.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rd_lane[gi] = bus.bus_rdata[gi*8 +: 8];
      assign wdata_fmt[gi*8 +: 8] =
        (Funct3[1:0] == 2'b00) ? WriteData[7:0] :
        (Funct3[1:0] == 2'b01) ? WriteData[(gi % 2)*8 +: 8] :
                                 WriteData[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    be_fmt = 4'b1111;
    case (Funct3[1:0])
      2'b00:   be_fmt = 4'b0001 << ALUResult[1:0];
      2'b01:   be_fmt = ALUResult[1] ? 4'b1100 : 4'b0011;
      default: be_fmt = 4'b1111;
    endcase
  end

  always_comb begin
    misalign  = ((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00));
    bad_load  = (Funct3[1:0] == 2'b11) || (Funct3 == 3'b110);
    bad_store = Funct3[2] || (Funct3 == 3'b011);
    illegal   = (MemRead && MemWrite) || misalign ||
                (MemRead && bad_load) || (MemWrite && bad_store);
  end

  always_comb begin
    byte_sel = rd_lane[addr_lo_reg];
    half_sel = addr_lo_reg[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (funct3_reg)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_fmt = {24'b0, byte_sel};
      3'b101:  load_fmt = {16'b0, half_sel};
      default: load_fmt = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      addr_lo_reg    <= 2'b00;
      funct3_reg     <= 3'b000;
      we_reg         <= 1'b0;
      bus_req_reg    <= 1'b0;
      bus_addr_reg   <= 32'b0;
      bus_be_reg     <= 4'b0000;
      bus_wdata_reg  <= 32'b0;
      read_data_reg  <= 32'b0;
      access_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          access_err_reg <= 1'b0;
          if (MemRead || MemWrite) begin
            addr_lo_reg   <= ALUResult[1:0];
            funct3_reg    <= Funct3;
            we_reg        <= MemWrite;
            bus_addr_reg  <= {ALUResult[31:2], 2'b00};
            bus_be_reg    <= be_fmt;
            bus_wdata_reg <= wdata_fmt;
            wait_cnt_reg  <= '0;
            if (illegal) begin
              state_reg      <= DONE;
              access_err_reg <= 1'b1;
              read_data_reg  <= 32'b0;
            end else begin
              state_reg   <= BUS;
              bus_req_reg <= 1'b1;
            end
          end
        end
        BUS: begin
          // An ack in the final allowed cycle still wins over the timeout.
          if (bus.bus_ack) begin
            state_reg   <= DONE;
            bus_req_reg <= 1'b0;
            if (!we_reg) read_data_reg <= load_fmt;
          end else if (wait_cnt_reg == CW'(TIMEOUT - 1)) begin
            state_reg      <= DONE;
            bus_req_reg    <= 1'b0;
            access_err_reg <= 1'b1;
            read_data_reg  <= 32'b0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + CW'(1);
          end
        end
        DONE: begin
          state_reg      <= IDLE;
          access_err_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Stall = reset && (((state_reg == IDLE) && (MemRead || MemWrite)) ||
                           (state_reg == BUS));

  assign ReadData      = read_data_reg;
  assign AccessErr     = access_err_reg;
  assign bus.bus_req   = bus_req_reg;
  assign bus.bus_we    = we_reg;
  assign bus.bus_addr  = bus_addr_reg;
  assign bus.bus_be    = bus_be_reg;
  assign bus.bus_wdata = bus_wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT=4: loads, stores, illegal accesses,
// timeout, ack at the timeout boundary and reset during a bus access.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] ALUResult, WriteData;
  logic [31:0] ReadData;
  logic        Stall, AccessErr;

  int checks = 0;
  int failures = 0;

  int          stall_n, req_n;
  logic [31:0] rd_done, b_addr, b_wdata;
  logic        err_done, b_we;
  logic [3:0]  b_be;

  load_store_unit_if bus_if ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .AccessErr(AccessErr),
    .bus(bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access to completion; ack_after = -1 means never acknowledge.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_after);
    logic done;
    done = 1'b0;
    MemRead = rd; MemWrite = wr; Funct3 = f3; ALUResult = addr; WriteData = wd;
    bus_if.bus_rdata = rdat; bus_if.bus_ack = 1'b0;
    stall_n = 0; req_n = 0; rd_done = 32'hx; err_done = 1'bx;
    b_addr = 32'b0; b_wdata = 32'b0; b_be = 4'b0; b_we = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (!Stall) begin
        rd_done = ReadData; err_done = AccessErr; done = 1'b1;
      end else begin
        stall_n++;
        if (bus_if.bus_req) begin
          if (req_n == 0) begin
            b_addr = bus_if.bus_addr; b_be = bus_if.bus_be;
            b_wdata = bus_if.bus_wdata; b_we = bus_if.bus_we;
          end
          bus_if.bus_ack = (ack_after >= 0) && (req_n == ack_after);
          req_n++;
        end
        tick();
        bus_if.bus_ack = 1'b0;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL access_done observed=not_done expected=done");
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    tick();
    $display("access f3=%03b addr=%08h stalls=%0d reqs=%0d rdata=%08h err=%0b",
             f3, addr, stall_n, req_n, rd_done, err_done);
  endtask

  initial begin
    reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
    ALUResult = 32'h100; WriteData = 32'b0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'b0;
    tick(); tick();
    check("rst_stall", {31'b0, Stall}, 32'd0);
    check("rst_rdata", ReadData, 32'h0);
    check("rst_err", {31'b0, AccessErr}, 32'd0);
    check("rst_req", {31'b0, bus_if.bus_req}, 32'd0);
    check("rst_be", {28'b0, bus_if.bus_be}, 32'h0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    MemRead = 1'b0; reset = 1'b1;
    tick();

    // LW 0x100, ack in the first BUS cycle
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_stall", stall_n, 2);
    check("lw_req", req_n, 1);
    check("lw_addr", b_addr, 32'h100);
    check("lw_be", {28'b0, b_be}, 32'hF);
    check("lw_we", {31'b0, b_we}, 32'd0);
    check("lw_rdata", rd_done, 32'hDEADBEEF);
    check("lw_err", {31'b0, err_done}, 32'd0);
    check("lw_hold", ReadData, 32'hDEADBEEF);

    access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lb_be", {28'b0, b_be}, 32'h8);
    check("lb_rdata", rd_done, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 0);
    check("lbu_rdata", rd_done, 32'h00000080);

    // LH with two wait cycles
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 2);
    check("lh_stall", stall_n, 4);
    check("lh_rdata", rd_done, 32'hFFFF80FF);
    access(1, 0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 0);
    check("lhu_be", {28'b0, b_be}, 32'h3);
    check("lhu_rdata", rd_done, 32'h0000F00D);

    access(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0);
    check("sh_we", {31'b0, b_we}, 32'd1);
    check("sh_addr", b_addr, 32'h100);
    check("sh_be", {28'b0, b_be}, 32'hC);
    check("sh_wdata", b_wdata, 32'hABCDABCD);
    check("sh_rdata", rd_done, 32'h0000F00D);

    access(0, 1, 3'b000, 32'h101, 32'hAABBCC55, 32'hFFFFFFFF, 0);
    check("sb_be", {28'b0, b_be}, 32'h2);
    check("sb_wdata", b_wdata, 32'h55555555);

    // Misaligned LW: no bus activity
    access(1, 0, 3'b010, 32'h101, 32'h0, 32'h12345678, 0);
    check("mis_stall", stall_n, 1);
    check("mis_req", req_n, 0);
    check("mis_err", {31'b0, err_done}, 32'd1);
    check("mis_rdata", rd_done, 32'h0);
    check("mis_err_pulse", {31'b0, AccessErr}, 32'd0);

    access(1, 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 1);
    check("lw1w_stall", stall_n, 3);
    check("lw1w_rdata", rd_done, 32'hCAFEF00D);

    // Timeout: no ack for TIMEOUT=4 cycles, then a late ack
    access(1, 0, 3'b010, 32'h300, 32'h0, 32'h11111111, -1);
    check("to_req", req_n, 4);
    check("to_stall", stall_n, 5);
    check("to_err", {31'b0, err_done}, 32'd1);
    check("to_rdata", rd_done, 32'h0);
    bus_if.bus_ack = 1'b1;
    #1;
    check("late_req", {31'b0, bus_if.bus_req}, 32'd0);
    check("late_stall", {31'b0, Stall}, 32'd0);
    tick();
    bus_if.bus_ack = 1'b0;
    check("late_rdata", ReadData, 32'h0);
    check("late_err", {31'b0, AccessErr}, 32'd0);

    access(0, 1, 3'b100, 32'h100, 32'h1, 32'h0, 0);
    check("badst_req", req_n, 0);
    check("badst_err", {31'b0, err_done}, 32'd1);
    access(1, 1, 3'b010, 32'h100, 32'h1, 32'h0, 0);
    check("both_err", {31'b0, err_done}, 32'd1);
    check("both_req", req_n, 0);
    access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    check("badld_err", {31'b0, err_done}, 32'd1);

    // Ack in the very cycle the timeout would fire
    access(1, 0, 3'b010, 32'h204, 32'h0, 32'h0BADF00D, 3);
    check("edge_req", req_n, 4);
    check("edge_err", {31'b0, err_done}, 32'd0);
    check("edge_rdata", rd_done, 32'h0BADF00D);

    // Reset asserted in the second BUS cycle, with an ack that must be discarded
    MemRead = 1'b1; Funct3 = 3'b010; ALUResult = 32'h300; bus_if.bus_rdata = 32'h77777777;
    tick();
    tick();
    check("rbus_req", {31'b0, bus_if.bus_req}, 32'd1);
    reset = 1'b0; bus_if.bus_ack = 1'b1;
    tick();
    check("rbus_req_drop", {31'b0, bus_if.bus_req}, 32'd0);
    check("rbus_stall", {31'b0, Stall}, 32'd0);
    check("rbus_rdata", ReadData, 32'h0);
    reset = 1'b1; MemRead = 1'b0; bus_if.bus_ack = 1'b0;
    #1;
    check("ridle_stall", {31'b0, Stall}, 32'd0);
    tick();
    check("ridle_req", {31'b0, bus_if.bus_req}, 32'd0);
    check("ridle_rdata", ReadData, 32'h0);
    check("ridle_err", {31'b0, AccessErr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
